mem_bist_seq: RTL and testbench

- Synthesizable write/read-back sequencer for the single-port `memory` block; replaces hand-driven bench sequencing of PC, mem_write and mem_read.
- On `start`, writes an address-derived pattern to DEPTH consecutive words from a base address, then reads them back pipelined, compares them, and reports pass/fail with error count and first failing address.
- Sits between a controller or bench and `memory`; drives its address, data and read/write strobes.

---
 rtl/mem_bist_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mem_bist_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_seq.sv
// Write/read-back memory self-test sequencer: writes an address-derived pattern
// to DEPTH words, reads them back through an RD_LAT-deep compare pipe, reports result.
module mem_bist_seq #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int STRIDE = 4,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [ADDR_W-1:0]            base_addr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_write,
  output logic                         mem_read,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(DEPTH+1)-1:0]   err_count,
  output logic [ADDR_W-1:0]            first_err_addr
);

  localparam int EC_W  = $clog2(DEPTH+1);
  localparam int IDX_W = EC_W;
  localparam int DR_W  = $clog2(RD_LAT+1);
  localparam int EXT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH-1);
  localparam logic [DR_W-1:0]   LAST_DR  = DR_W'(RD_LAT-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DR_W-1:0]   drain_q, drain_d;
  logic [EC_W-1:0]   err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              pass_q, pass_d;

  // Expected-data delay pipe, aligned with the memory read latency.
  logic              pv_q    [RD_LAT];
  logic [DATA_W-1:0] pdata_q [RD_LAT];
  logic [ADDR_W-1:0] paddr_q [RD_LAT];

  logic              push;
  logic [DATA_W-1:0] cur_pattern;
  logic              cmp_valid;
  logic              mismatch;

  function automatic logic [DATA_W-1:0] pattern_f(input logic [ADDR_W-1:0] a,
                                                  input logic odd,
                                                  input logic [1:0] m);
    logic [EXT_W-1:0]  ext;
    logic [DATA_W-1:0] word;
    ext  = EXT_W'(a >> 2);
    word = ext[DATA_W-1:0];
    case (m)
      2'd0:    pattern_f = word;
      2'd1:    pattern_f = ~word;
      2'd2:    pattern_f = odd ? DATA_W'({DATA_W/2{2'b01}}) : DATA_W'({DATA_W/2{2'b10}});
      default: pattern_f = '1;
    endcase
  endfunction

  assign cur_pattern = pattern_f(addr_q, idx_q[0], mode_q);
  assign cmp_valid   = pv_q[RD_LAT-1];

  // Case inequality so an undriven (X) read word is reported as a failure.
  always_comb begin
    mismatch = 1'b0;
    if (cmp_valid && (mem_rdata !== pdata_q[RD_LAT-1])) begin
      mismatch = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
    push    = 1'b0;

    if (mismatch) begin
      if (err_q == '0) begin
        ferr_d = paddr_q[RD_LAT-1];
      end
      err_d = err_q + EC_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d  = base_addr;
          mode_d  = mode;
          addr_d  = base_addr;
          idx_d   = '0;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          addr_d  = base_q;
          state_d = S_READ;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          addr_d = addr_q + STRIDE_A;
        end
      end
      S_READ: begin
        push = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          addr_d = addr_q + STRIDE_A;
        end
      end
      S_DRAIN: begin
        // The last compare lands on the same edge that enters DONE.
        if (drain_q == LAST_DR) begin
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) begin
        pv_q[k]    <= 1'b0;
        pdata_q[k] <= '0;
        paddr_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
      pv_q[0]    <= push;
      pdata_q[0] <= cur_pattern;
      paddr_q[0] <= addr_q;
      for (int k = 1; k < RD_LAT; k++) begin
        pv_q[k]    <= pv_q[k-1];
        pdata_q[k] <= pdata_q[k-1];
        paddr_q[k] <= paddr_q[k-1];
      end
    end
  end

  always_comb begin
    mem_write      = (state_q == S_WRITE);
    mem_read       = (state_q == S_READ);
    mem_addr       = (mem_write || mem_read) ? addr_q : '0;
    mem_wdata      = mem_write ? cur_pattern : '0;
    busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    done           = (state_q == S_DONE);
    pass           = done && pass_q;
    err_count      = err_q;
    first_err_addr = ferr_q;
  end

endmodule

// File: tb/tb_mem_bist_seq.sv
// Bench for mem_bist_seq: two instances (default and DEPTH=8/RD_LAT=3) with
// behavioural memories, a write/read scoreboard and directed runs.
module tb_mem_bist_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults
  logic        start_a = 1'b0;
  logic [1:0]  mode_a = '0;
  logic [63:0] base_a = '0;
  logic [63:0] mem_addr_a, mem_wdata_a, rdata_a, ferr_a;
  logic        mem_write_a, mem_read_a, busy_a, done_a, pass_a;
  logic [2:0]  err_a;

  // Instance B: deeper run, longer read latency
  logic        start_b = 1'b0;
  logic [1:0]  mode_b = '0;
  logic [63:0] base_b = '0;
  logic [63:0] mem_addr_b, mem_wdata_b, rdata_b, ferr_b;
  logic        mem_write_b, mem_read_b, busy_b, done_b, pass_b;
  logic [3:0]  err_b;

  mem_bist_seq u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .mode(mode_a), .base_addr(base_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_write(mem_write_a),
    .mem_read(mem_read_a), .mem_rdata(rdata_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_addr(ferr_a)
  );

  mem_bist_seq #(.DEPTH(8), .RD_LAT(3)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode_b), .base_addr(base_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_write(mem_write_b),
    .mem_read(mem_read_b), .mem_rdata(rdata_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_err_addr(ferr_b)
  );

  // Behavioural memories; a stored word at a chosen address gets bit0 flipped.
  logic [63:0] mem_a [1024];
  logic [63:0] mem_b [1024];
  logic [63:0] c0_a = '0, c1_a = '0, c0_b = '0;
  logic        c0_a_en = 1'b0, c1_a_en = 1'b0, c0_b_en = 1'b0;
  logic [63:0] rp0_b, rp1_b;

  always @(posedge clk) begin
    if (mem_write_a)
      mem_a[mem_addr_a[11:2]] <= mem_wdata_a ^
        {63'd0, ((c0_a_en && mem_addr_a == c0_a) || (c1_a_en && mem_addr_a == c1_a))};
    rdata_a <= mem_read_a ? mem_a[mem_addr_a[11:2]] : 64'hx;
  end

  always @(posedge clk) begin
    if (mem_write_b)
      mem_b[mem_addr_b[11:2]] <= mem_wdata_b ^ {63'd0, (c0_b_en && mem_addr_b == c0_b)};
    rp0_b   <= mem_read_b ? mem_b[mem_addr_b[11:2]] : 64'hx;
    rp1_b   <= rp0_b;
    rdata_b <= rp1_b;
  end

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         wq_a[$], wq_b[$];
  logic [63:0] rq_a[$], rq_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [63:0] a, input int i, input logic [1:0] m);
    case (m)
      2'd0:    return a >> 2;
      2'd1:    return ~(a >> 2);
      2'd2:    return (i % 2 == 1) ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Scoreboard pop side: every strobe must match the next expected transaction.
  always @(negedge clk) begin
    wr_t w;
    if (mem_write_a && mem_read_a) chk("a_strobe_excl", 64'd1, 64'd0);
    if (mem_write_b && mem_read_b) chk("b_strobe_excl", 64'd1, 64'd0);
    if (mem_write_a) begin
      chk("a_wr_expected", 64'(wq_a.size() != 0), 64'd1);
      if (wq_a.size() != 0) begin
        w = wq_a.pop_front();
        chk("a_wr_addr", mem_addr_a, w.addr);
        chk("a_wr_data", mem_wdata_a, w.data);
      end
    end
    if (mem_read_a) begin
      chk("a_rd_expected", 64'(rq_a.size() != 0), 64'd1);
      if (rq_a.size() != 0) chk("a_rd_addr", mem_addr_a, rq_a.pop_front());
    end
    if (mem_write_b) begin
      chk("b_wr_expected", 64'(wq_b.size() != 0), 64'd1);
      if (wq_b.size() != 0) begin
        w = wq_b.pop_front();
        chk("b_wr_addr", mem_addr_b, w.addr);
        chk("b_wr_data", mem_wdata_b, w.data);
      end
    end
    if (mem_read_b) begin
      chk("b_rd_expected", 64'(rq_b.size() != 0), 64'd1);
      if (rq_b.size() != 0) chk("b_rd_addr", mem_addr_b, rq_b.pop_front());
    end
  end

  task automatic push_a(input logic [63:0] base, input logic [1:0] m);
    logic [63:0] a;
    for (int i = 0; i < 4; i++) begin
      a = base + 64'(i * 4);
      wq_a.push_back('{addr: a, data: pat(a, i, m)});
      rq_a.push_back(a);
    end
  endtask

  task automatic run_a(input logic [63:0] base, input logic [1:0] m,
                       input int exp_err, input logic [63:0] exp_first);
    int n;
    push_a(base, m);
    @(posedge clk); #1;
    base_a = base; mode_a = m; start_a = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      if (n == 1) start_a = 1'b0;
    end while (!done_a && n < 100);
    chk("a_done_latency", 64'(n), 64'd10);
    chk("a_done", 64'(done_a), 64'd1);
    chk("a_busy", 64'(busy_a), 64'd0);
    chk("a_pass", 64'(pass_a), 64'(exp_err == 0));
    chk("a_err_count", 64'(err_a), 64'(exp_err));
    chk("a_first_err", ferr_a, exp_first);
    chk("a_queues_empty", 64'(wq_a.size() + rq_a.size()), 64'd0);
    $display("run A base=%0h mode=%0d: cycles=%0d err=%0d first=%0h pass=%0b",
             base, m, n, err_a, ferr_a, pass_a);
  endtask

  task automatic run_b(input logic [63:0] base, input logic [1:0] m, input bit poke,
                       input int exp_err, input logic [63:0] exp_first);
    int n;
    logic [63:0] a;
    for (int i = 0; i < 8; i++) begin
      a = base + 64'(i * 4);
      wq_b.push_back('{addr: a, data: pat(a, i, m)});
      rq_b.push_back(a);
    end
    @(posedge clk); #1;
    base_b = base; mode_b = m; start_b = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      if (n == 1) start_b = 1'b0;
      if (poke && n == 3) begin
        start_b = 1'b1; base_b = 64'h800; mode_b = 2'd3;
      end
      if (poke && n == 4) start_b = 1'b0;
    end while (!done_b && n < 100);
    chk("b_done_latency", 64'(n), 64'd20);
    chk("b_pass", 64'(pass_b), 64'(exp_err == 0));
    chk("b_err_count", 64'(err_b), 64'(exp_err));
    chk("b_first_err", ferr_b, exp_first);
    chk("b_queues_empty", 64'(wq_b.size() + rq_b.size()), 64'd0);
    $display("run B base=%0h mode=%0d poke=%0b: cycles=%0d err=%0d first=%0h pass=%0b",
             base, m, poke, n, err_b, ferr_b, pass_b);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_outs_a", 64'(|{mem_addr_a, mem_wdata_a, mem_write_a, mem_read_a, busy_a,
                            done_a, pass_a, err_a, ferr_a}), 64'd0);
    chk("rst_outs_b", 64'(|{mem_addr_b, mem_wdata_b, mem_write_b, mem_read_b, busy_b,
                            done_b, pass_b, err_b, ferr_b}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_a(64'h0, 2'd0, 0, 64'h0);
    repeat (3) @(posedge clk);
    #1 chk("a_done_sticky", 64'(done_a), 64'd1);

    run_a(64'h100, 2'd1, 0, 64'h0);

    c0_a = 64'h8; c0_a_en = 1'b1;
    run_a(64'h0, 2'd0, 1, 64'h8);

    c0_a = 64'h4; c1_a = 64'hC; c1_a_en = 1'b1;
    run_a(64'h0, 2'd0, 2, 64'h4);
    c0_a_en = 1'b0; c1_a_en = 1'b0;

    run_a(64'hFFFF_FFFF_FFFF_FFF8, 2'd0, 0, 64'h0);
    run_a(64'h40, 2'd3, 0, 64'h0);

    // Abort mid-READ with an asynchronous reset
    push_a(64'h0, 2'd2);
    @(posedge clk); #1;
    base_a = 64'h0; mode_a = 2'd2; start_a = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk); n++; #1;
      if (n == 1) start_a = 1'b0;
    end
    chk("a_midread_busy", 64'(mem_read_a), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("a_async_rst_outs", 64'(|{mem_addr_a, mem_wdata_a, mem_write_a, mem_read_a, busy_a,
                                  done_a, pass_a, err_a, ferr_a}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wq_a.delete();
    rq_a.delete();
    $display("run A aborted by reset after %0d cycles", n);
    run_a(64'h0, 2'd2, 0, 64'h0);

    run_b(64'h200, 2'd2, 1'b1, 0, 64'h0);
    c0_b = 64'h21C; c0_b_en = 1'b1;
    run_b(64'h200, 2'd0, 1'b0, 1, 64'h21C);
    c0_b_en = 1'b0;

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

endmodule
